cluster_clk_gate: RTL and testbench

Glitch-free, latch-based integrated clock gate for cluster-level power saving. Used, for example, to stop the storage clock of a FIFO while it idles. Adds a programmable hold-off that keeps the clock running a few cycles after the enable drops, a test-mode override, and a saturating counter of enabled cycles for power monitoring. All sequential logic except the gate latch runs on the ungated clock clk.

---
 rtl/cluster_clk_gate.sv | 64 ++++++
 tb/tb_cluster_clk_gate.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_clk_gate.sv
// Latch-based integrated clock gate with enable hold-off, test override and
// a saturating counter of clock pulses passed through to clk_o.
module cluster_clk_gate #(
    parameter int unsigned HOLD_CYCLES = 0,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 test_en_i,
    input  logic                 cnt_clr_i,
    output logic                 clk_o,
    output logic                 clk_en_o,
    output logic [CNT_WIDTH-1:0] active_cnt_o
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    logic [HoldW-1:0]     r_hold_cnt;
    logic [CNT_WIDTH-1:0] r_active_cnt;
    logic                 r_en_q;
    logic                 w_hold_active;
    logic                 w_req;

    assign w_hold_active = (r_hold_cnt != '0);
    assign w_req         = en_i | test_en_i | w_hold_active;

    // Hold-off counter: reload on every enabled edge, then count down to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (en_i) begin
            r_hold_cnt <= HoldW'(HOLD_CYCLES);
        end else if (w_hold_active) begin
            r_hold_cnt <= r_hold_cnt - HoldW'(1);
        end
    end

    // Enable latch, transparent in the low phase so clk_o highs are never cut short.
    always_latch begin
        if (!rst_n) begin
            r_en_q <= 1'b0;
        end else if (!clk) begin
            r_en_q <= w_req;
        end
    end

    assign clk_o    = clk & r_en_q;
    assign clk_en_o = r_en_q;

    // Activity counter: counts edges that reach clk_o, clear wins, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_active_cnt <= '0;
        end else if (r_en_q && (r_active_cnt != '1)) begin
            r_active_cnt <= r_active_cnt + CNT_WIDTH'(1);
        end
    end

    assign active_cnt_o = r_active_cnt;

endmodule

// File: tb/tb_cluster_clk_gate.sv
// Bench for cluster_clk_gate: a plain HOLD=0 instance and a HOLD=3 / 3-bit
// counter instance share stimulus; both are checked against a cycle model.
module tb_cluster_clk_gate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic        test_en_i;
    logic        cnt_clr_i;
    logic        clk_o0, clk_o3;
    logic        clk_en0, clk_en3;
    logic [15:0] cnt0;
    logic [2:0]  cnt3;
    logic [1:0]  w_clk_o;
    logic [1:0]  w_clk_en;

    assign w_clk_o  = {clk_o3, clk_o0};
    assign w_clk_en = {clk_en3, clk_en0};

    always #5 clk = ~clk;

    cluster_clk_gate #(.HOLD_CYCLES(0), .CNT_WIDTH(16)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .test_en_i    (test_en_i),
        .cnt_clr_i    (cnt_clr_i),
        .clk_o        (clk_o0),
        .clk_en_o     (clk_en0),
        .active_cnt_o (cnt0)
    );

    cluster_clk_gate #(.HOLD_CYCLES(3), .CNT_WIDTH(3)) u_dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .test_en_i    (test_en_i),
        .cnt_clr_i    (cnt_clr_i),
        .clk_o        (clk_o3),
        .clk_en_o     (clk_en3),
        .active_cnt_o (cnt3)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: edges since the last enabled edge, and pulse count.
    int       hold_h [2] = '{0, 3};
    int       cnt_max[2] = '{65535, 7};
    int       m_since[2];
    int       m_cnt  [2];
    bit [1:0] m_prev;

    function automatic int cnt_of(input int i);
        return (i == 0) ? int'(cnt0) : int'(cnt3);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_since[i] = hold_h[i];
            m_cnt[i]   = 0;
        end
        m_prev = 2'b00;
    endfunction

    // One clk cycle. Entered and left at posedge+2 (mid high phase), so input
    // changes always land while clk is high.
    task automatic step(input bit en, input bit tst, input bit clr, output bit [1:0] pulses);
        bit [1:0] exp;
        en_i      = en;
        test_en_i = tst;
        cnt_clr_i = clr;
        for (int i = 0; i < 2; i++) exp[i] = en | tst | (m_since[i] < hold_h[i]);
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (w_clk_o[i] !== m_prev[i]) begin
                errors++;
                $display("FAIL mid_high dut%0d cyc%0d: got %b want %b", i, cyc, w_clk_o[i],
                         m_prev[i]);
            end
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (w_clk_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL low_phase dut%0d cyc%0d: got %b want 0", i, cyc, w_clk_o[i]);
            end
            checks++;
            if (w_clk_en[i] !== exp[i]) begin
                errors++;
                $display("FAIL clk_en dut%0d cyc%0d: got %b want %b", i, cyc, w_clk_en[i], exp[i]);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (exp[i] && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
            if (en) m_since[i] = 0;
            else if (m_since[i] < hold_h[i]) m_since[i]++;
            checks++;
            if (w_clk_o[i] !== exp[i]) begin
                errors++;
                $display("FAIL pulse dut%0d cyc%0d: got %b want %b", i, cyc, w_clk_o[i], exp[i]);
            end
            checks++;
            if (cnt_of(i) != m_cnt[i]) begin
                errors++;
                $display("FAIL active_cnt dut%0d cyc%0d: got %0d want %0d", i, cyc, cnt_of(i),
                         m_cnt[i]);
            end
        end
        pulses = w_clk_o;
        m_prev = exp;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        bit [1:0] p;
        rst_n     = 1'b0;
        en_i      = 1'b1;
        test_en_i = 1'b1;
        cnt_clr_i = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            checks++;
            if (w_clk_o !== 2'b00 || w_clk_en !== 2'b00) begin
                errors++;
                $display("FAIL reset_gate: got clk_o=%b clk_en=%b want 00/00", w_clk_o, w_clk_en);
            end
            checks++;
            if (cnt0 !== 16'd0 || cnt3 !== 3'd0) begin
                errors++;
                $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt3);
            end
        end
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, p);
        checks++;
        if (p !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_pulse: got %b want 11", p);
        end
    endtask

    task automatic test_basic_gating();
        bit [1:0] p;
        int       n = 0;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, p);
        step(1'b0, 1'b0, 1'b1, p);
        for (int k = 0; k < 8; k++) begin
            step((k < 5), 1'b0, 1'b0, p);
            n += int'(p[0]);
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL basic_pulses: got %0d want 5", n);
        end
        checks++;
        if (cnt0 !== 16'd5) begin
            errors++;
            $display("FAIL basic_cnt: got %0d want 5", cnt0);
        end
    endtask

    task automatic test_glitch();
        bit [1:0] p;
        for (int k = 0; k < 10; k++) step(1'($urandom_range(1, 0)), 1'b0, 1'b0, p);
    endtask

    task automatic test_hold();
        bit [1:0] p;
        int       n = 0;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, p);
        step(1'b1, 1'b0, 1'b0, p);
        n += int'(p[1]);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, p);
            n += int'(p[1]);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL hold_single: got %0d want 4", n);
        end
        // Enable at steps 0 and 3: pulses 0..3 plus three hold pulses.
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step((k == 0 || k == 3), 1'b0, 1'b0, p);
            n += int'(p[1]);
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL hold_restart: got %0d want 7", n);
        end
    endtask

    task automatic test_override();
        bit [1:0] p;
        int       n = 0;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, p);
        step(1'b0, 1'b0, 1'b1, p);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 1'b0, p);
            n += int'(p[0]);
        end
        checks++;
        if (n != 8 || cnt0 !== 16'd8) begin
            errors++;
            $display("FAIL override: got pulses=%0d cnt=%0d want 8/8", n, cnt0);
        end
        step(1'b0, 1'b0, 1'b0, p);
        checks++;
        if (p !== 2'b00) begin
            errors++;
            $display("FAIL override_stop: got %b want 00", p);
        end
    endtask

    task automatic test_saturation();
        bit [1:0] p;
        step(1'b0, 1'b0, 1'b1, p);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, p);
        checks++;
        if (cnt3 !== 3'd7) begin
            errors++;
            $display("FAIL saturate: got %0d want 7", cnt3);
        end
        step(1'b1, 1'b0, 1'b1, p);
        checks++;
        if (cnt3 !== 3'd0) begin
            errors++;
            $display("FAIL clear_priority: got %0d want 0", cnt3);
        end
        step(1'b1, 1'b0, 1'b0, p);
        checks++;
        if (cnt3 !== 3'd1) begin
            errors++;
            $display("FAIL after_clear: got %0d want 1", cnt3);
        end
    endtask

    task automatic test_random();
        bit [1:0] p;
        for (int k = 0; k < 40; k++) begin
            step(1'($urandom_range(99, 0) < 40), 1'($urandom_range(99, 0) < 10),
                 1'($urandom_range(99, 0) < 8), p);
        end
    endtask

    task automatic test_async_reset();
        bit [1:0] p;
        step(1'b1, 1'b0, 1'b0, p);
        step(1'b1, 1'b0, 1'b0, p);
        // Now mid high phase with clk_o running on both instances.
        rst_n     = 1'b0;
        test_en_i = 1'b1;
        #1;
        checks++;
        if (w_clk_o !== 2'b00 || w_clk_en !== 2'b00 || cnt0 !== 16'd0 || cnt3 !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got clk_o=%b en=%b cnt=%0d/%0d want 00/00/0/0", w_clk_o,
                     w_clk_en, cnt0, cnt3);
        end
        @(posedge clk);
        #2;
        checks++;
        if (w_clk_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: got %b want 00", w_clk_o);
        end
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 1'b0, p);
        step(1'b0, 1'b0, 1'b0, p);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, p);
    endtask

    initial begin
        test_reset();
        test_basic_gating();
        test_glitch();
        test_hold();
        test_override();
        test_saturation();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
